decoder_nto2n_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder: SEL_W-bit code to 2**SEL_W one-hot outputs.
- Two modes:
  - DIRECT: registers the decode of an external code.
  - SCAN: an internal counter walks the outputs with a programmable dwell.
- Used as a row/column/channel strobe generator in the datapath, generalising the fixed 2-to-4 gate decoder.

---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_onehot.sv | 15 +
 rtl/decoder_nto2n_seq.sv | 174 +++++++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced binary-to-one-hot decoder:
// mode encodings and the controller state encoding.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIRECT = 2'b01,
        ST_SCAN   = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_onehot.sv
// Purely combinational SEL_W-bit code to 2**SEL_W one-hot mapping.
module decoder_onehot #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      code,
    output logic [(1<<SEL_W)-1:0] onehot
);

    // Exactly one bit set at the position named by code.
    always_comb begin
        onehot       = {(1<<SEL_W){1'b0}};
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2**N strobe decoder with DIRECT and SCAN (dwelling walk) modes.
// Optional index skipping in SCAN is enabled by defining DECODER_SKIP_EN.
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef DECODER_SKIP_EN
    input  logic [(1<<SEL_W)-1:0] skip_mask,
`endif
    output logic [(1<<SEL_W)-1:0] y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      scan_idx,
    output logic                  wrap
);

    localparam int N = 1 << SEL_W;

    state_e             state_q, state_d;
    logic [N-1:0]       y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [N-1:0]       mask_s;
    logic               all_masked_s;
    logic               scan_active_s;
    logic [SEL_W-1:0]   code_s;
    logic [N-1:0]       onehot_s;

`ifdef DECODER_SKIP_EN
    assign mask_s = skip_mask;
`else
    assign mask_s = {N{1'b0}};
`endif
    assign all_masked_s = &mask_s;

    function automatic logic [SEL_W-1:0] lowest_unmasked(input logic [N-1:0] m);
        logic [SEL_W-1:0] res;
        res = {SEL_W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            res = m[k] ? res : SEL_W'(k);
        end
        return res;
    endfunction

    // Search upward from idx (modulo N); k=N lands back on idx itself.
    function automatic logic [SEL_W-1:0] next_unmasked(input logic [SEL_W-1:0] idx,
                                                       input logic [N-1:0]     m);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] cand;
        logic             found;
        logic             hit;
        res   = idx;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand  = idx + SEL_W'(k);
            hit   = !found && !m[cand];
            res   = hit ? cand : res;
            found = found | hit;
        end
        return res;
    endfunction

    // Controller: state, scan index, dwell counter and wrap pulse.
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        wrap_d        = 1'b0;
        scan_active_s = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            scan_idx_d = {SEL_W{1'b0}};
            cnt_d      = {DWELL_W{1'b0}};
        end else if (mode == MODE_DIRECT) begin
            state_d    = ST_DIRECT;
            scan_idx_d = {SEL_W{1'b0}};
            cnt_d      = {DWELL_W{1'b0}};
        end else begin
            state_d = ST_SCAN;
            // A SCAN cycle with y_valid low means the walk was stalled on a full mask.
            if (all_masked_s) begin
                cnt_d = {DWELL_W{1'b0}};
            end else if ((state_q != ST_SCAN) || !y_valid_q) begin
                scan_idx_d    = lowest_unmasked(mask_s);
                cnt_d         = {DWELL_W{1'b0}};
                dwell_d       = dwell;
                scan_active_s = 1'b1;
            end else if (cnt_q == dwell_q) begin
                scan_idx_d    = next_unmasked(scan_idx_q, mask_s);
                cnt_d         = {DWELL_W{1'b0}};
                dwell_d       = dwell;
                wrap_d        = (scan_idx_d <= scan_idx_q);
                scan_active_s = 1'b1;
            end else begin
                cnt_d         = cnt_q + DWELL_W'(1);
                scan_active_s = 1'b1;
            end
        end
    end

    assign code_s = (mode == MODE_SCAN) ? scan_idx_d : sel;

    decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
        .code   (code_s),
        .onehot (onehot_s)
    );

    // Strobe output: entering DIRECT without a valid code yields no strobe.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (!en) begin
            y_d       = {N{1'b0}};
            y_valid_d = 1'b0;
        end else if (mode == MODE_DIRECT) begin
            if (sel_valid) begin
                y_d       = onehot_s;
                y_valid_d = 1'b1;
            end else if (state_q != ST_DIRECT) begin
                y_d       = {N{1'b0}};
                y_valid_d = 1'b0;
            end else begin
                y_d       = y_q;
                y_valid_d = y_valid_q;
            end
        end else if (scan_active_s) begin
            y_d       = onehot_s;
            y_valid_d = 1'b1;
        end else begin
            y_d       = {N{1'b0}};
            y_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            y_q        <= {N{1'b0}};
            y_valid_q  <= 1'b0;
            scan_idx_q <= {SEL_W{1'b0}};
            wrap_q     <= 1'b0;
            cnt_q      <= {DWELL_W{1'b0}};
            dwell_q    <= {DWELL_W{1'b0}};
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            scan_idx_q <= scan_idx_d;
            wrap_q     <= wrap_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign scan_idx = scan_idx_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Table-driven directed bench for decoder_nto2n_seq (SEL_W=2, DWELL_W=4).
module tb_decoder_nto2n_seq;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
    localparam int N       = 1 << SEL_W;

    logic               clk;
    logic               rst;
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic [DWELL_W-1:0] dwell;
    logic [N-1:0]       skip_mask;
    logic [N-1:0]       y;
    logic               y_valid;
    logic [SEL_W-1:0]   scan_idx;
    logic               wrap;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic               rst;
        logic               en;
        logic               mode;
        logic [SEL_W-1:0]   sel;
        logic               sel_valid;
        logic [DWELL_W-1:0] dwell;
        logic [N-1:0]       exp_y;
        logic               exp_yv;
        logic [SEL_W-1:0]   exp_idx;
        logic               exp_wrap;
    } vec_t;

    vec_t vecs[$];

    decoder_nto2n_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .sel_valid (sel_valid),
        .dwell     (dwell),
`ifdef DECODER_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .y         (y),
        .y_valid   (y_valid),
        .scan_idx  (scan_idx),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic m, input int s, input logic sv,
                       input int d, input logic [N-1:0] ey, input logic eyv, input int eidx,
                       input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sel = SEL_W'(s); v.sel_valid = sv;
        v.dwell = DWELL_W'(d); v.exp_y = ey; v.exp_yv = eyv; v.exp_idx = SEL_W'(eidx);
        v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input int s,
                         input logic sv, input int d);
        rst = r; en = e; mode = m; sel = SEL_W'(s); sel_valid = sv; dwell = DWELL_W'(d);
    endtask

    task automatic cmp(input string name, input logic [N-1:0] ey, input logic eyv,
                       input logic [SEL_W-1:0] eidx, input logic ew);
        n_vec++;
        if ({y, y_valid, scan_idx, wrap} !== {ey, eyv, eidx, ew}) begin
            n_err++;
            $display("FAIL %s: got y=%b y_valid=%b scan_idx=%0d wrap=%b, want y=%b y_valid=%b scan_idx=%0d wrap=%b",
                     name, y, y_valid, scan_idx, wrap, ey, eyv, eidx, ew);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx_exp[9];
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        skip_mask = 4'b0000;

        //   rst  en   mode sel sv   dw  y        yv   idx wrap
        add(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 3, 1'b1, 0, 4'b1000, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 4'b1000, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 0, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2, 1'b1, 0, 4'b0100, 1'b1, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 2, 1'b1, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1, 1'b1, 0, 4'b0010, 1'b1, 0, 1'b0);
        // scan with dwell=1: two cycles per index
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0010, 1'b1, 1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0010, 1'b1, 1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0100, 1'b1, 2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0100, 1'b1, 2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b1000, 1'b1, 3, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b1000, 1'b1, 3, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0001, 1'b1, 0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 4'b0010, 1'b1, 1, 1'b0);
        // scan -> direct, then direct -> scan with dwell=0
        add(1'b0, 1'b1, 1'b0, 2, 1'b1, 0, 4'b0100, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0010, 1'b1, 1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0100, 1'b1, 2, 1'b0);
        // reset mid-scan at index 2
        add(1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0001, 1'b1, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0010, 1'b1, 1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0100, 1'b1, 2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b1000, 1'b1, 3, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0001, 1'b1, 0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0010, 1'b1, 1, 1'b0);
        // disable mid-scan, re-enable restarts at index 0
        add(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 4'b0001, 1'b1, 0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, int'(vecs[i].sel),
                  vecs[i].sel_valid, int'(vecs[i].dwell));
            step();
            cmp($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_yv,
                vecs[i].exp_idx, vecs[i].exp_wrap);
        end

        // Dwell raised 1->3 while index 1 is showing: idx1 keeps 2 cycles, idx2 gets 4.
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 1);
        step();
        idx_exp = '{0, 0, 1, 1, 2, 2, 2, 2, 3};
        for (int t = 0; t < 9; t++) begin
            drive(1'b0, 1'b1, 1'b1, 0, 1'b0, (t >= 3) ? 3 : 1);
            step();
            cmp($sformatf("dwell_chg%0d", t), 4'b0001 << idx_exp[t], 1'b1,
                SEL_W'(idx_exp[t]), 1'b0);
        end

        // Periodicity with dwell=1: period 8, wrap at each return to index 0.
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 1);
        step();
        for (int t = 0; t < 24; t++) begin
            drive(1'b0, 1'b1, 1'b1, 0, 1'b0, 1);
            step();
            cmp($sformatf("period%0d", t), 4'b0001 << ((t / 2) % N), 1'b1,
                SEL_W'((t / 2) % N), (t > 0) && (t % 8 == 0));
        end

`ifdef DECODER_SKIP_EN
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
        step();
        skip_mask = 4'b0101;
        drive(1'b0, 1'b1, 1'b1, 0, 1'b0, 0);
        step(); cmp("skip_entry", 4'b0010, 1'b1, 2'd1, 1'b0);
        step(); cmp("skip_a",     4'b1000, 1'b1, 2'd3, 1'b0);
        step(); cmp("skip_b",     4'b0010, 1'b1, 2'd1, 1'b1);
        step(); cmp("skip_c",     4'b1000, 1'b1, 2'd3, 1'b0);
        step(); cmp("skip_d",     4'b0010, 1'b1, 2'd1, 1'b1);
        step(); cmp("skip_e",     4'b1000, 1'b1, 2'd3, 1'b0);
        skip_mask = 4'b1111;
        step(); cmp("skip_all",   4'b0000, 1'b0, 2'd3, 1'b0);
        step(); cmp("skip_all2",  4'b0000, 1'b0, 2'd3, 1'b0);
        skip_mask = 4'b0000;
        step(); cmp("skip_resume", 4'b0001, 1'b1, 2'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
